// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO between the host register interface and the
// UART TX serialiser. The host pushes with tWR, the serialiser pops with tRD;
// pop data is registered and appears one cycle after the accepting edge.
// Optional build macro TXFIFO_ERR_STICKY_EN adds sticky {ovf, udf} error bits
// on tErr, cleared by tErrClr; without it tErr reads 2'b00.
module uart_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                         tClk,
  input  logic                         tRst,
  input  logic                         tWR,
  input  logic [WIDTH-1:0]             tdataIn,
  input  logic                         tRD,
  input  logic                         tFlush,
  input  logic                         tErrClr,
  output logic [WIDTH-1:0]             tdataOut,
  output logic                         tEMPTY,
  output logic                         tFULL,
  output logic                         tAFULL,
  output logic                         ttxrdy,
  output logic [$clog2(DEPTH):0]       tCount,
  output logic                         tOvf,
  output logic                         tUdf,
  output logic [1:0]                   tErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AFULL = (AW+1)'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] dout;
  logic             ovf;
  logic             udf;

  logic push_ok;
  logic pop_ok;
  logic ovf_set;
  logic udf_set;

  // Flags come straight from the occupancy register so they always agree with tCount.
  always_comb begin
    tEMPTY  = (cnt == '0);
    tFULL   = (cnt == CNT_FULL);
    tAFULL  = (cnt >= CNT_AFULL);
    ttxrdy  = (cnt != '0);
    // Acceptance uses the flags as they stood before this edge; flush overrides both.
    push_ok = tWR && !tFULL && !tFlush;
    pop_ok  = tRD && !tEMPTY && !tFlush;
    ovf_set = tWR && tFULL && !tFlush;
    udf_set = tRD && tEMPTY && !tFlush;
  end

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge tClk) begin
    if (push_ok) begin
      mem[wptr] <= tdataIn;
    end
  end

  // Pointers, occupancy, registered pop data and the one-cycle error pulses.
  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      dout <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (tFlush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      dout <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      ovf <= ovf_set;
      udf <= udf_set;
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + AW'(1);
      end
      // Simultaneous accepted push and pop leave the occupancy unchanged.
      if (push_ok && !pop_ok) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

  assign tdataOut = dout;
  assign tCount   = cnt;
  assign tOvf     = ovf;
  assign tUdf     = udf;

`ifdef TXFIFO_ERR_STICKY_EN
  logic [1:0] err;

  // Sticky error bits: a set event in the same cycle as tErrClr wins.
  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      err <= 2'b00;
    end else begin
      err[1] <= ovf_set | (err[1] & ~tErrClr);
      err[0] <= udf_set | (err[0] & ~tErrClr);
    end
  end

  assign tErr = err;
`else
  logic unused_errclr;
  assign unused_errclr = tErrClr;
  assign tErr = 2'b00;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed plus randomized bench for uart_tx_fifo
// (WIDTH=8, DEPTH=4, AFULL_LVL=3). A queue-based model predicts every output.
// Honors TXFIFO_ERR_STICKY_EN the same way the design does.
module tb_uart_tx_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = 3;

  logic       tClk = 1'b0;
  logic       tRst = 1'b0;
  logic       tWR = 1'b0;
  logic       tRD = 1'b0;
  logic       tFlush = 1'b0;
  logic       tErrClr = 1'b0;
  logic [7:0] tdataIn = 8'h00;
  logic [7:0] tdataOut;
  logic       tEMPTY, tFULL, tAFULL, ttxrdy, tOvf, tUdf;
  logic [2:0] tCount;
  logic [1:0] tErr;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .tClk(tClk), .tRst(tRst), .tWR(tWR), .tdataIn(tdataIn), .tRD(tRD),
    .tFlush(tFlush), .tErrClr(tErrClr), .tdataOut(tdataOut), .tEMPTY(tEMPTY),
    .tFULL(tFULL), .tAFULL(tAFULL), .ttxrdy(ttxrdy), .tCount(tCount),
    .tOvf(tOvf), .tUdf(tUdf), .tErr(tErr)
  );

  always #5 tClk = ~tClk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [1:0] m_err = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, "_count"}, 32'(tCount), 32'(n));
    chk({tag, "_empty"}, 32'(tEMPTY), 32'(n == 0));
    chk({tag, "_full"},  32'(tFULL),  32'(n == DEPTH));
    chk({tag, "_afull"}, 32'(tAFULL), 32'(n >= AFULL_LVL));
    chk({tag, "_txrdy"}, 32'(ttxrdy), 32'(n != 0));
    chk({tag, "_dout"},  32'(tdataOut), 32'(m_dout));
    chk({tag, "_ovf"},   32'(tOvf), 32'(m_ovf));
    chk({tag, "_udf"},   32'(tUdf), 32'(m_udf));
    chk({tag, "_err"},   32'(tErr), 32'(m_err));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input logic wr, input logic rd, input logic fl, input logic clr,
                     input logic [7:0] d, input string tag);
    int  n;
    logic [1:0] ev;
    tWR = wr; tRD = rd; tFlush = fl; tErrClr = clr; tdataIn = d;
    @(posedge tClk);
    n = q.size();
    ev = 2'b00;
    if (fl) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = wr && (n == DEPTH);
      m_udf = rd && (n == 0);
      ev = {m_ovf, m_udf};
      if (rd && n != 0) m_dout = q.pop_front();
      if (wr && n != DEPTH) q.push_back(d);
    end
`ifdef TXFIFO_ERR_STICKY_EN
    m_err = ev | (clr ? 2'b00 : m_err);
`else
    m_err = 2'b00;
`endif
    #1;
    $display("%-10s wr=%0b rd=%0b fl=%0b clr=%0b din=%02h | cnt=%0d dout=%02h ovf=%0b udf=%0b err=%02b",
             tag, wr, rd, fl, clr, d, tCount, tdataOut, tOvf, tUdf, tErr);
    check_model(tag);
  endtask

  initial begin
    // reset state
    #12;
    check_model("reset");
    chk("reset_dout", 32'(tdataOut), 32'h00);
    tRst = 1'b1;
    cyc(0, 0, 0, 0, 8'h00, "idle");
    chk("idle_empty", 32'(tEMPTY), 32'd1);

    // fill to almost-full, full, then overflow
    cyc(1, 0, 0, 0, 8'hA1, "push_a1");
    cyc(1, 0, 0, 0, 8'hA2, "push_a2");
    cyc(1, 0, 0, 0, 8'hA3, "push_a3");
    chk("afull_at3", 32'(tAFULL), 32'd1);
    cyc(1, 0, 0, 0, 8'hA4, "push_a4");
    chk("full_at4", 32'(tFULL), 32'd1);
    cyc(1, 0, 0, 0, 8'hA5, "push_ovf");
    chk("ovf_pulse", 32'(tOvf), 32'd1);
    chk("ovf_count", 32'(tCount), 32'd4);
    cyc(0, 0, 0, 0, 8'h00, "ovf_drop");

    // drain in order, then underflow
    cyc(0, 1, 0, 0, 8'h00, "pop1");
    chk("pop1_data", 32'(tdataOut), 32'hA1);
    cyc(0, 1, 0, 0, 8'h00, "pop2");
    chk("pop2_data", 32'(tdataOut), 32'hA2);
    cyc(0, 1, 0, 0, 8'h00, "pop3");
    chk("pop3_data", 32'(tdataOut), 32'hA3);
    cyc(0, 1, 0, 0, 8'h00, "pop4");
    chk("pop4_data", 32'(tdataOut), 32'hA4);
    cyc(0, 1, 0, 0, 8'h00, "pop_udf");
    chk("udf_pulse", 32'(tUdf), 32'd1);
    chk("udf_hold", 32'(tdataOut), 32'hA4);
`ifdef TXFIFO_ERR_STICKY_EN
    chk("err_set", 32'(tErr), 32'h3);
`endif
    cyc(0, 0, 0, 1, 8'h00, "err_clr");
    chk("err_clr", 32'(tErr), 32'h0);

    // interleaved traffic across the pointer wrap
    cyc(1, 0, 0, 0, 8'hB0, "wrap_p0");
    cyc(1, 0, 0, 0, 8'hB1, "wrap_p1");
    for (int i = 2; i < 6; i++) begin
      cyc(1, 1, 0, 0, 8'hB0 + 8'(i), "wrap_pp");
      chk("wrap_cnt2", 32'(tCount), 32'd2);
    end
    cyc(0, 1, 0, 0, 8'h00, "wrap_q1");
    cyc(0, 1, 0, 0, 8'h00, "wrap_q2");
    chk("wrap_last", 32'(tdataOut), 32'hB5);

    // simultaneous push+pop at the full and empty boundaries
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'hC0 + 8'(i), "fill");
    cyc(1, 1, 0, 0, 8'hCF, "full_wr_rd");
    chk("full_wr_rd_cnt", 32'(tCount), 32'd3);
    chk("full_wr_rd_ovf", 32'(tOvf), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00, "drain");
    cyc(1, 1, 0, 0, 8'hD0, "empty_wr_rd");
    chk("empty_wr_rd_cnt", 32'(tCount), 32'd1);
    chk("empty_wr_rd_udf", 32'(tUdf), 32'd1);

    // flush beats a concurrent push
    cyc(1, 0, 0, 0, 8'hD1, "pre_flush");
    cyc(1, 0, 1, 0, 8'hD2, "flush");
    chk("flush_cnt", 32'(tCount), 32'd0);
    chk("flush_dout", 32'(tdataOut), 32'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) == 0),
          8'($urandom), "rand");
    end

    // asynchronous reset in the middle of a push
    cyc(1, 0, 0, 0, 8'hE0, "pre_rst");
    tWR = 1'b1; tdataIn = 8'hE1;
    #2;
    tRst = 1'b0;
    #1;
    q.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0; m_err = 2'b00;
    check_model("async_rst");
    chk("async_rst_cnt", 32'(tCount), 32'd0);
    @(posedge tClk);
    #1;
    tWR = 1'b0;
    tRst = 1'b1;
    cyc(0, 0, 0, 0, 8'h00, "post_rst");
    cyc(0, 1, 0, 0, 8'h00, "post_rst_udf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
